// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_edge input conditioner.
// Holds the debounce FSM state encoding and the stability-counter width helper.
package debounce_pkg;

    // Two stable states, plus one "waiting for confirmation" state per direction.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_e;

    // Number of bits needed to hold the values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
// Both flops load RST_VAL while rst is high, so the output is a known level straight out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    // First flop may go metastable; the second gives it a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            q_reg    <= RST_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: turns a bouncy raw input into a clean debounced level, one-cycle
// rise/fall pulses and a wrapping count of accepted rises.
// Build option: define DEBOUNCE_SYNC_EN to place a 2-flop synchronizer in front of the
// FSM (adds two cycles of latency). Without it, din must already be synchronous to clk.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int            SW          = cnt_width(STABLE_CYCLES);
    // Terminal count: a change is accepted on the sample that finds stab_cnt at N-1,
    // i.e. the N-th consecutive sample at the new value.
    localparam logic [SW-1:0] CNT_LAST    = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] CNT_ONE     = SW'(1);
    localparam deb_state_e    RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic samp;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff #(
        .RST_VAL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (samp)
    );
`else
    assign samp = din;
`endif

    deb_state_e       state_reg,    state_next;
    logic [SW-1:0]    stab_cnt_reg, stab_cnt_next;
    logic             level_reg,    level_next;
    logic             rise_reg,     rise_next;
    logic             fall_reg,     fall_next;
    logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;

    // State, counter and all outputs are registered; reset aborts any pending window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RESET_STATE;
            stab_cnt_reg <= '0;
            level_reg    <= RESET_LEVEL;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
            edge_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            stab_cnt_reg <= stab_cnt_next;
            level_reg    <= level_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
            edge_cnt_reg <= edge_cnt_next;
        end
    end

    // Next-state logic: any sample back at the old level throws the window away;
    // pulses are only ever produced on the transition out of a WAIT state.
    always_comb begin
        state_next    = state_reg;
        stab_cnt_next = stab_cnt_reg;
        level_next    = level_reg;
        rise_next     = 1'b0;
        fall_next     = 1'b0;
        edge_cnt_next = edge_cnt_reg;

        case (state_reg)
            STABLE_LO: begin
                if (samp) begin
                    state_next    = WAIT_HI;
                    stab_cnt_next = CNT_ONE;
                end
            end

            WAIT_HI: begin
                if (!samp) begin
                    state_next    = STABLE_LO;
                    stab_cnt_next = '0;
                end else if (stab_cnt_reg == CNT_LAST) begin
                    state_next    = STABLE_HI;
                    stab_cnt_next = '0;
                    level_next    = 1'b1;
                    rise_next     = 1'b1;
                    edge_cnt_next = edge_cnt_reg + CNT_W'(1);
                end else begin
                    stab_cnt_next = stab_cnt_reg + CNT_ONE;
                end
            end

            STABLE_HI: begin
                if (!samp) begin
                    state_next    = WAIT_LO;
                    stab_cnt_next = CNT_ONE;
                end
            end

            WAIT_LO: begin
                if (samp) begin
                    state_next    = STABLE_HI;
                    stab_cnt_next = '0;
                end else if (stab_cnt_reg == CNT_LAST) begin
                    state_next    = STABLE_LO;
                    stab_cnt_next = '0;
                    level_next    = 1'b0;
                    fall_next     = 1'b1;
                end else begin
                    stab_cnt_next = stab_cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next    = RESET_STATE;
                stab_cnt_next = '0;
            end
        endcase
    end

    assign level    = level_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;
    assign edge_cnt = edge_cnt_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Testbench for debounce_edge with STABLE_CYCLES=4, CNT_W=8.
// Expected pulses are queued when stimulus is applied and matched by a monitor when the DUT pulses.
module tb_debounce_edge;

    localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N;
`endif

    logic       clk;
    logic       rst;
    logic       din;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] edge_cnt;

    debounce_edge #(
        .STABLE_CYCLES (N),
        .RESET_LEVEL   (1'b0),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt)
    );

    typedef struct {
        int         cyc;
        bit         is_rise;
        logic       lvl;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    logic [7:0] exp_cnt    = 8'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rise === 1'b1 && fall === 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL both_pulses cyc=%0d rise=%b fall=%b required at most one", cyc, rise, fall);
        end else if (rise === 1'b1 || fall === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b required none", cyc, rise, fall);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || rise !== mon_e.is_rise || level !== mon_e.lvl || edge_cnt !== mon_e.cnt) begin
                    mismatched++;
                    $display("FAIL pulse cyc=%0d rise=%b level=%b cnt=%0d required cyc=%0d rise=%b level=%b cnt=%0d",
                             cyc, rise, level, edge_cnt, mon_e.cyc, mon_e.is_rise, mon_e.lvl, mon_e.cnt);
                end else begin
                    $display("pulse ok cyc=%0d rise=%b level=%b cnt=%0d", cyc, rise, level, edge_cnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input bit r, input logic l, input logic [7:0] n);
        sb.push_back('{cyc: c, is_rise: r, lvl: l, cnt: n});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            compared++;
            if ({level, rise, fall} !== 3'b000 || edge_cnt !== 8'd0) begin
                mismatched++;
                $display("FAIL reset_state lvl/rise/fall=%b cnt=%0d required 000 cnt=0", {level, rise, fall}, edge_cnt);
            end
        end
        din = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_cnt = 8'd0;
        tick(2);
        $display("test_reset done");
    endtask

    task automatic test_rise_latency();
        int c0;
        tick(1);
        din = 1'b1;
        c0 = cyc;
        exp_cnt++;
        push_exp(c0 + LAT, 1'b1, 1'b1, exp_cnt);
        tick(LAT - 1);
        compared++;
        if (level !== 1'b0) begin
            mismatched++;
            $display("FAIL early_level level=%b required 0 one cycle before acceptance", level);
        end
        tick(1);
        compared++;
        if (level !== 1'b1 || edge_cnt !== exp_cnt) begin
            mismatched++;
            $display("FAIL accept_level level=%b cnt=%0d required 1 cnt=%0d", level, edge_cnt, exp_cnt);
        end
        tick(1);
        compared++;
        if (rise !== 1'b0 || level !== 1'b1) begin
            mismatched++;
            $display("FAIL rise_width rise=%b level=%b required rise=0 level=1", rise, level);
        end
        tick(3);
        din = 1'b0;
        push_exp(cyc + LAT, 1'b0, 1'b0, exp_cnt);
        tick(LAT + 3);
        compared++;
        if (sb.size() != 0 || level !== 1'b0) begin
            mismatched++;
            $display("FAIL rise_fall_drain pending=%0d level=%b required 0 and 0", sb.size(), level);
        end
        sb.delete();
        $display("test_rise_latency done");
    endtask

    task automatic test_glitch();
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(LAT + 4);
        compared++;
        if (level !== 1'b0 || edge_cnt !== exp_cnt) begin
            mismatched++;
            $display("FAIL glitch level=%b cnt=%0d required 0 cnt=%0d", level, edge_cnt, exp_cnt);
        end
        $display("test_glitch done");
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 21; i++) begin
            tick(1);
            din = ~din;
        end
        exp_cnt++;
        push_exp(cyc + LAT, 1'b1, 1'b1, exp_cnt);
        tick(LAT + 3);
        compared++;
        if (sb.size() != 0 || level !== 1'b1 || edge_cnt !== exp_cnt) begin
            mismatched++;
            $display("FAIL toggle pending=%0d level=%b cnt=%0d required 0 1 %0d", sb.size(), level, edge_cnt, exp_cnt);
        end
        sb.delete();
        din = 1'b0;
        push_exp(cyc + LAT, 1'b0, 1'b0, exp_cnt);
        tick(LAT + 3);
        sb.delete();
        $display("test_toggle done");
    endtask

    task automatic test_reset_mid_wait();
        tick(1);
        din = 1'b1;
        tick(LAT - 2);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            compared++;
            if (level !== 1'b0 || rise !== 1'b0 || edge_cnt !== 8'd0) begin
                mismatched++;
                $display("FAIL mid_wait_reset level=%b rise=%b cnt=%0d required 0 0 0", level, rise, edge_cnt);
            end
        end
        rst = 1'b0;
        exp_cnt = 8'd1;
        push_exp(cyc + LAT, 1'b1, 1'b1, exp_cnt);
        tick(LAT - 1);
        compared++;
        if (level !== 1'b0) begin
            mismatched++;
            $display("FAIL fresh_window level=%b required 0 before full window", level);
        end
        tick(4);
        compared++;
        if (sb.size() != 0 || level !== 1'b1) begin
            mismatched++;
            $display("FAIL after_release pending=%0d level=%b required 0 1", sb.size(), level);
        end
        sb.delete();
        din = 1'b0;
        push_exp(cyc + LAT, 1'b0, 1'b0, exp_cnt);
        tick(LAT + 3);
        sb.delete();
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_cnt = 8'd0;
        tick(1);
        for (int k = 0; k < 256; k++) begin
            din = 1'b1;
            exp_cnt++;
            push_exp(cyc + LAT, 1'b1, 1'b1, exp_cnt);
            tick(LAT + 1);
            din = 1'b0;
            push_exp(cyc + LAT, 1'b0, 1'b0, exp_cnt);
            tick(LAT + 1);
        end
        tick(2);
        compared++;
        if (edge_cnt !== 8'd0 || sb.size() != 0 || level !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap cnt=%0d pending=%0d level=%b required cnt=0 pending=0 level=0", edge_cnt, sb.size(), level);
        end
        sb.delete();
        $display("test_wrap done");
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_toggle();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
